// File: rtl/trigger_sequencer.sv
// Sample-strobe sequencer for the 24-channel input latch: masked coincidence trigger, deadtime,
// and a first-word fall-through event FIFO. Optional macro TRIG_TIMESTAMP_EN adds evt_time.
module trigger_sequencer #(
  parameter int WIDTH      = 24,
  parameter int PERIOD_W   = 16,
  parameter int DEAD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                sampling_clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DEAD_W-1:0]   deadtime,
  input  logic [WIDTH-1:0]    mask,
  input  logic [4:0]          threshold,
  output logic                sample_interrupt,
  input  logic [WIDTH-1:0]    latched,
  output logic                trig,
  output logic                busy,
  output logic [WIDTH-1:0]    evt_data,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                overflow,
  input  logic                clear_ovf
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [31:0]         evt_time
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DEAD} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, per_m1;
  logic [DEAD_W-1:0]   dcnt_q, dcnt_d;
  logic [WIDTH-1:0]    hits;
  logic                pass, push;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  assign hits   = latched & mask;
  assign pass   = (32'(popcount(hits)) >= 32'(threshold));
  assign per_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dcnt_d           = dcnt_q;
    sample_interrupt = 1'b0;
    push             = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        dcnt_d = '0;
        if (arm) state_d = WAIT;
      end
      WAIT: begin
        if (!arm) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == per_m1) begin
          sample_interrupt = 1'b1;
          cnt_d            = '0;
          state_d          = CAPTURE;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      CAPTURE: begin
        // evaluation completes even when arm has just dropped
        cnt_d = '0;
        push  = pass;
        if (!arm) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (pass && (deadtime != '0)) begin
          state_d = DEAD;
          dcnt_d  = deadtime;
        end else begin
          state_d = WAIT;
        end
      end
      DEAD: begin
        if (!arm) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q <= DEAD_W'(1)) begin
          state_d = WAIT;
          dcnt_d  = '0;
          cnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q - DEAD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      trig    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      trig    <= push;
    end
  end

  // Event FIFO: a pop frees the slot for a same-cycle push when full
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             pop, full, accept, drop;

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == FULL_CNT);
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (accept) mem[wr_ptr] <= hits;
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] tmem [FIFO_DEPTH];

  always_ff @(posedge sampling_clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge sampling_clk) begin
    if (accept) tmem[wr_ptr] <= ts_q;
  end

  assign evt_time = evt_valid ? tmem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: directed scenarios plus randomized runs against an event-level model.
module tb_trigger_sequencer;
  localparam int WIDTH = 24;

  logic             sampling_clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             arm = 1'b0;
  logic [15:0]      period = 16'd1;
  logic [15:0]      deadtime = 16'd0;
  logic [WIDTH-1:0] mask = '1;
  logic [4:0]       threshold = 5'd0;
  logic             sample_interrupt;
  logic [WIDTH-1:0] latched = '0;
  logic             trig;
  logic             busy;
  logic [WIDTH-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic             overflow;
  logic             clear_ovf = 1'b0;
`ifdef TRIG_TIMESTAMP_EN
  logic [31:0]      evt_time;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 sampling_clk = ~sampling_clk;

  trigger_sequencer dut (
    .sampling_clk     (sampling_clk),
    .rst_n            (rst_n),
    .arm              (arm),
    .period           (period),
    .deadtime         (deadtime),
    .mask             (mask),
    .threshold        (threshold),
    .sample_interrupt (sample_interrupt),
    .latched          (latched),
    .trig             (trig),
    .busy             (busy),
    .evt_data         (evt_data),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .overflow         (overflow),
    .clear_ovf        (clear_ovf)
`ifdef TRIG_TIMESTAMP_EN
    ,
    .evt_time         (evt_time)
`endif
  );

  task automatic cyc();
    @(posedge sampling_clk);
    #1;
  endtask

  task automatic do_reset();
    arm = 1'b0; evt_ready = 1'b0; clear_ovf = 1'b0; latched = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge sampling_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    arm = 1'b1; period = 16'd2; threshold = 5'd0; mask = '1; evt_ready = 1'b0;
    repeat (6) cyc();
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (sample_interrupt !== 1'b0) $display("FAIL reset_strobe got %0b want 0", sample_interrupt); else n_pass++;
    n_total++; if (trig !== 1'b0) $display("FAIL reset_trig got %0b want 0", trig); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid got %0b want 0", evt_valid); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else n_pass++;
    n_total++; if (evt_data !== '0) $display("FAIL reset_evt_data got %h want 0", evt_data); else n_pass++;
    arm = 1'b0;
    cyc();
    rst_n = 1'b1;
    #3;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_periodic();
    logic exp_s, exp_t;
    period = 16'd5; deadtime = 16'd0; threshold = 5'd0; mask = '1;
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      cyc();
      arm = 1'b1; latched = WIDTH'($urandom);
      #3;
      exp_s = (c == 5 || c == 11 || c == 17);
      exp_t = (c == 7 || c == 13 || c == 19);
      n_total++; if (sample_interrupt !== exp_s) $display("FAIL periodic_strobe c=%0d got %0b want %0b", c, sample_interrupt, exp_s); else n_pass++;
      n_total++; if (trig !== exp_t) $display("FAIL periodic_trig c=%0d got %0b want %0b", c, trig, exp_t); else n_pass++;
      n_total++; if (evt_valid !== (c >= 7)) $display("FAIL periodic_evt_valid c=%0d got %0b want %0b", c, evt_valid, (c >= 7)); else n_pass++;
      n_total++; if (busy !== (c >= 1)) $display("FAIL periodic_busy c=%0d got %0b want %0b", c, busy, (c >= 1)); else n_pass++;
    end
    arm = 1'b0;
  endtask

  task automatic test_mask_threshold();
    logic exp_s, exp_t;
    period = 16'd3; deadtime = 16'd0; threshold = 5'd2; mask = 24'h00000F;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      cyc();
      arm = 1'b1;
      latched = (c <= 6) ? 24'hF00003 : 24'h000001;
      evt_ready = (c == 12);
      #3;
      exp_s = (c == 3 || c == 7 || c == 11);
      exp_t = (c == 5);
      n_total++; if (sample_interrupt !== exp_s) $display("FAIL mask_strobe c=%0d got %0b want %0b", c, sample_interrupt, exp_s); else n_pass++;
      n_total++; if (trig !== exp_t) $display("FAIL mask_trig c=%0d got %0b want %0b", c, trig, exp_t); else n_pass++;
      if (c >= 5 && c <= 12) begin
        n_total++; if (evt_valid !== 1'b1) $display("FAIL mask_evt_valid c=%0d got %0b want 1", c, evt_valid); else n_pass++;
        n_total++; if (evt_data !== 24'h000003) $display("FAIL mask_evt_data c=%0d got %h want 000003", c, evt_data); else n_pass++;
      end
      if (c == 13) begin
        n_total++; if (evt_valid !== 1'b0) $display("FAIL mask_drained_valid got %0b want 0", evt_valid); else n_pass++;
        n_total++; if (evt_data !== '0) $display("FAIL mask_drained_data got %h want 0", evt_data); else n_pass++;
      end
    end
    arm = 1'b0; evt_ready = 1'b0;
  endtask

  task automatic test_deadtime();
    logic exp_s, exp_t;
    period = 16'd1; deadtime = 16'd10; threshold = 5'd0; mask = '1;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      cyc();
      arm = 1'b1; evt_ready = 1'b1; latched = WIDTH'($urandom);
      #3;
      exp_s = (c == 1 || c == 13 || c == 25);
      exp_t = (c == 3 || c == 15);
      n_total++; if (sample_interrupt !== exp_s) $display("FAIL dead_strobe c=%0d got %0b want %0b", c, sample_interrupt, exp_s); else n_pass++;
      n_total++; if (trig !== exp_t) $display("FAIL dead_trig c=%0d got %0b want %0b", c, trig, exp_t); else n_pass++;
    end
    arm = 1'b0; evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic exp_t;
    logic [WIDTH-1:0] exp_d;
    period = 16'd1; deadtime = 16'd0; threshold = 5'd0; mask = '1;
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      cyc();
      arm = (c < 10);
      latched = {3{8'(c)}};
      #3;
      exp_t = (c == 3 || c == 5 || c == 7 || c == 9 || c == 11);
      n_total++; if (trig !== exp_t) $display("FAIL ovf_trig c=%0d got %0b want %0b", c, trig, exp_t); else n_pass++;
      n_total++; if (overflow !== (c == 11)) $display("FAIL ovf_flag c=%0d got %0b want %0b", c, overflow, (c == 11)); else n_pass++;
      n_total++; if (busy !== (c >= 1 && c <= 10)) $display("FAIL ovf_busy c=%0d got %0b want %0b", c, busy, (c >= 1 && c <= 10)); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      evt_ready = 1'b1;
      #3;
      exp_d = {3{8'(2 + 2 * k)}};
      n_total++; if (evt_valid !== 1'b1) $display("FAIL drain_valid k=%0d got %0b want 1", k, evt_valid); else n_pass++;
      n_total++; if (evt_data !== exp_d) $display("FAIL drain_data k=%0d got %h want %h", k, evt_data, exp_d); else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL drain_sticky k=%0d got %0b want 1", k, overflow); else n_pass++;
    end
    cyc();
    evt_ready = 1'b0; clear_ovf = 1'b1;
    #3;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL drain_empty got %0b want 0", evt_valid); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL clear_pending got %0b want 1", overflow); else n_pass++;
    cyc();
    clear_ovf = 1'b0;
    #3;
    n_total++; if (overflow !== 1'b0) $display("FAIL clear_ovf got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_disarm_reset();
    period = 16'd4; deadtime = 16'd0; threshold = 5'd0; mask = '1;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      cyc();
      arm = (c < 2);
      #3;
      n_total++; if (sample_interrupt !== 1'b0) $display("FAIL disarm_strobe c=%0d got %0b want 0", c, sample_interrupt); else n_pass++;
      n_total++; if (busy !== (c == 1 || c == 2)) $display("FAIL disarm_busy c=%0d got %0b want %0b", c, busy, (c == 1 || c == 2)); else n_pass++;
    end
    deadtime = 16'd20;
    for (int c = 0; c <= 8; c++) begin
      cyc();
      arm = 1'b1;
      #3;
      n_total++; if (sample_interrupt !== (c == 4)) $display("FAIL rearm_strobe c=%0d got %0b want %0b", c, sample_interrupt, (c == 4)); else n_pass++;
      n_total++; if (trig !== (c == 6)) $display("FAIL rearm_trig c=%0d got %0b want %0b", c, trig, (c == 6)); else n_pass++;
      n_total++; if (busy !== (c >= 1)) $display("FAIL rearm_busy c=%0d got %0b want %0b", c, busy, (c >= 1)); else n_pass++;
    end
    n_total++; if (evt_valid !== 1'b1) $display("FAIL dead_evt_valid got %0b want 1", evt_valid); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL async_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL async_evt_valid got %0b want 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== '0) $display("FAIL async_evt_data got %h want 0", evt_data); else n_pass++;
    n_total++; if (sample_interrupt !== 1'b0) $display("FAIL async_strobe got %0b want 0", sample_interrupt); else n_pass++;
    n_total++; if (trig !== 1'b0) $display("FAIL async_trig got %0b want 0", trig); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL async_overflow got %0b want 0", overflow); else n_pass++;
    arm = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

`ifdef TRIG_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] t0;
    period = 16'd1; deadtime = 16'd5; threshold = 5'd0; mask = '1;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      cyc();
      arm = (c < 10);
      #3;
    end
    n_total++; if (evt_valid !== 1'b1) $display("FAIL ts_valid got %0b want 1", evt_valid); else n_pass++;
    t0 = evt_time;
    cyc();
    evt_ready = 1'b1;
    #3;
    cyc();
    evt_ready = 1'b0;
    #3;
    n_total++; if (evt_time - t0 !== 32'd7) $display("FAIL ts_delta got %0d want 7", evt_time - t0); else n_pass++;
    cyc();
    evt_ready = 1'b1;
    #3;
    cyc();
    evt_ready = 1'b0;
    #3;
    n_total++; if (evt_time !== 32'd0) $display("FAIL ts_empty got %h want 0", evt_time); else n_pass++;
  endtask
`endif

  // Event-level model: strobe/capture times from period and deadtime arithmetic, FIFO as a queue.
  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      int p_eff, d, next_strobe, cap_cycle, trig_cycle;
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] hits_m, exp_d;
      logic ovf_m, pass_m, pop_m, drop_m;
      period    = 16'($urandom_range(0, 4));
      deadtime  = 16'($urandom_range(0, 5));
      mask      = (run == 6) ? '0 : WIDTH'($urandom);
      threshold = (run == 7) ? 5'd25 : (run == 6) ? 5'd0 : 5'($urandom_range(0, 12));
      p_eff = (period == 16'd0) ? 1 : int'(period);
      d = int'(deadtime);
      do_reset();
      q.delete();
      ovf_m = 1'b0; next_strobe = p_eff; cap_cycle = -1; trig_cycle = -1;
      for (int c = 0; c < 150; c++) begin
        cyc();
        arm = 1'b1;
        latched = WIDTH'($urandom) | WIDTH'($urandom);
        evt_ready = ($urandom_range(0, 2) == 0);
        clear_ovf = ($urandom_range(0, 9) == 0);
        #3;
        exp_d = (q.size() != 0) ? q[0] : '0;
        n_total++; if (sample_interrupt !== (c == next_strobe)) $display("FAIL rnd_strobe run=%0d c=%0d got %0b want %0b", run, c, sample_interrupt, (c == next_strobe)); else n_pass++;
        n_total++; if (trig !== (c == trig_cycle)) $display("FAIL rnd_trig run=%0d c=%0d got %0b want %0b", run, c, trig, (c == trig_cycle)); else n_pass++;
        n_total++; if (busy !== (c >= 1)) $display("FAIL rnd_busy run=%0d c=%0d got %0b want %0b", run, c, busy, (c >= 1)); else n_pass++;
        n_total++; if (evt_valid !== (q.size() != 0)) $display("FAIL rnd_evt_valid run=%0d c=%0d got %0b want %0b", run, c, evt_valid, (q.size() != 0)); else n_pass++;
        n_total++; if (evt_data !== exp_d) $display("FAIL rnd_evt_data run=%0d c=%0d got %h want %h", run, c, evt_data, exp_d); else n_pass++;
        n_total++; if (overflow !== ovf_m) $display("FAIL rnd_overflow run=%0d c=%0d got %0b want %0b", run, c, overflow, ovf_m); else n_pass++;
        pass_m = 1'b0; drop_m = 1'b0;
        hits_m = latched & mask;
        if (c == next_strobe) cap_cycle = c + 1;
        if (c == cap_cycle) begin
          pass_m = ($countones(hits_m) >= int'(threshold));
          if (pass_m) trig_cycle = c + 1;
          next_strobe = c + p_eff + (pass_m ? d : 0);
        end
        pop_m = (q.size() != 0) && evt_ready;
        if (pop_m) void'(q.pop_front());
        if (pass_m) begin
          if (q.size() < 4) q.push_back(hits_m);
          else drop_m = 1'b1;
        end
        if (drop_m) ovf_m = 1'b1;
        else if (clear_ovf) ovf_m = 1'b0;
      end
      arm = 1'b0; evt_ready = 1'b0; clear_ovf = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_mask_threshold();
    test_deadtime();
    test_overflow();
    test_disarm_reset();
`ifdef TRIG_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Controller for the 24-channel input latch.
- Issues the latch's sample strobe on a programmable period and evaluates each latched word against a channel mask and coincidence threshold.
- On a pass, pulses a trigger, enforces deadtime, and queues the hit pattern in a small FIFO for host readout over a valid/ready handshake.
- Sits between the latch and the readout/host interface.

Parameters:
- WIDTH, 24, number of input channels / latched word width
- PERIOD_W, 16, width of sample period register
- DEAD_W, 16, width of deadtime register
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
- sampling_clk  in  1  sole clock; same clock as the latch
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level; 1 = run sampling, 0 = return to IDLE
- period  in  PERIOD_W  cycles between strobes; 0 treated as 1
- deadtime  in  DEAD_W  idle cycles after a trigger
- mask  in  WIDTH  channel enable
- threshold  in  5  minimum popcount(latched & mask) to trigger
- sample_interrupt  out  1  one-cycle strobe to the latch
- latched  in  WIDTH  latch output word
- trig  out  1  one-cycle trigger pulse
- busy  out  1  high in any state except IDLE
- evt_data  out  WIDTH  FIFO head: masked hit pattern
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head
- overflow  out  1  sticky; an event was dropped
- clear_ovf  in  1  clears overflow

Behaviour:
- Reset: state=IDLE, all counters 0, FIFO empty. Outputs sample_interrupt=0, trig=0, busy=0, evt_valid=0, overflow=0, evt_data=0.
- IDLE: arm=1 -> WAIT with cnt=0.
- WAIT: cnt increments each cycle. When cnt==max(period,1)-1, sample_interrupt=1 for exactly that cycle, cnt clears, go CAPTURE. With period=1, the strobe repeats at most every 2 cycles, since CAPTURE intervenes.
- CAPTURE: latched is valid in this cycle, because the latch updates on the strobe edge.
  - Compute hits=latched&mask and pop=popcount(hits).
  - pop>=threshold: at the next edge trig=1 for one cycle and hits is pushed to the FIFO. If deadtime==0 go WAIT, else go DEAD with dcnt=deadtime.
  - Otherwise go WAIT.
  - Strobe-to-trig latency: 2 cycles.
- DEAD: dcnt decrements; leaving when dcnt==1 -> WAIT with cnt=0. Exactly `deadtime` cycles are spent in DEAD. No strobes are issued during DEAD.
- Disarm: arm=0 in any state -> IDLE at the next edge; cnt and dcnt clear.
  - If arm falls during CAPTURE, the evaluation still completes: trig and push occur, then IDLE.
  - FIFO contents and overflow are preserved.
- threshold=0: every sample triggers, including when mask=0.
- threshold>WIDTH: never triggers.
- period, deadtime, mask and threshold are sampled live. A change takes effect at the next comparison.
- FIFO behaviour:
  - First-word fall-through: evt_data is the head whenever evt_valid=1, and 0 when empty.
  - A pop occurs when evt_valid&&evt_ready.
  - Push while full and no pop in the same cycle: event dropped, overflow set, trig still pulses.
  - Push while full with a pop in the same cycle: push accepted.
  - Push and pop when empty: the push wins and evt_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: clear_ovf clears it. If clear_ovf coincides with a new drop, overflow stays set.

Optional Feature:
- Macro TRIG_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit counter cleared by reset, wrapping at 2^32-1 -> 0.
  - Adds output port evt_time[31:0].
  - Each FIFO entry stores the counter value from the CAPTURE cycle; evt_time presents it alongside evt_data, and is 0 when empty.
- Undefined: no counter, no evt_time port; FIFO stores hit pattern only.

Test Plan:
- Reset then arm=1, period=5, threshold=0, deadtime=0 -> sample_interrupt on cycles 5,11,17 after arm; trig 2 cycles after each strobe; evt_valid rises.
- mask=0x00000F, threshold=2, latched=0x000003 on one sample and 0x000001 on the next -> first triggers, evt_data=0x000003; second gives no trig and no push.
- Trigger with deadtime=10, period=1 -> no sample_interrupt for 10 cycles after trig, then strobes resume.
- evt_ready=0, 5 triggering samples, FIFO_DEPTH=4 -> 4 entries kept, overflow=1. Drain 4 in order with evt_ready=1, then pulse clear_ovf -> overflow=0.
- Deassert arm mid-WAIT, then assert rst_n=0 mid-DEAD -> IDLE/busy=0 next edge; reset clears all outputs immediately (asynchronous).
- With TRIG_TIMESTAMP_EN: two triggers 7 cycles apart -> evt_time values differ by 7.
